pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage: holds the architectural fetch PC, advances it through a valid/ready fetch handshake, and applies prioritised redirects for taken branches, JALR and traps. It generalises the fixed 64-bit, always-advancing PC to a configurable XLEN, reset vector and step, and adds stall, flush and misaligned-target detection. It sits between the control unit/execute stage, which sources redirects, and instruction memory, which consumes `pc` and `fetch_valid`.

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_redirect_arb.sv | 44 ++++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC sequencer: redirect source encoding and alignment mask.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ  = 2'd0,
    PC_SRC_BR   = 2'd1,
    PC_SRC_JALR = 2'd2,
    PC_SRC_TRAP = 2'd3
  } pc_src_t;

  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: target adders, trap > JALR > branch priority, and
// alignment check on branch/JALR targets (trap targets are trusted).
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                   br_taken,
  input  logic        [XLEN-1:0] br_pc,
  input  logic signed [XLEN-1:0] br_imm,
  input  logic                   jalr_taken,
  input  logic        [XLEN-1:0] jalr_base,
  input  logic signed [XLEN-1:0] jalr_imm,
  input  logic                   trap,
  input  logic        [XLEN-1:0] trap_vector,
  output pc_src_t                src,
  output logic        [XLEN-1:0] target,
  output logic                   misaligned
);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;

  assign br_tgt   = br_pc + br_imm;
  assign jalr_tgt = (jalr_base + jalr_imm) & ~XLEN'(1);

  always_comb begin
    src    = PC_SRC_SEQ;
    target = '0;
    if (trap) begin
      src    = PC_SRC_TRAP;
      target = trap_vector;
    end else if (jalr_taken) begin
      src    = PC_SRC_JALR;
      target = jalr_tgt;
    end else if (br_taken) begin
      src    = PC_SRC_BR;
      target = br_tgt;
    end
    misaligned = ((src == PC_SRC_BR) || (src == PC_SRC_JALR)) &&
                 ((target[1:0] & PC_ALIGN_MASK) != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: registered PC with valid/ready handshake and prioritised redirects.
// Optional accepted-fetch counter is built only when PC_FETCH_CNT_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              CNT_W        = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic        [XLEN-1:0] br_pc,
  input  logic signed [XLEN-1:0] br_imm,
  input  logic                   jalr_taken,
  input  logic        [XLEN-1:0] jalr_base,
  input  logic signed [XLEN-1:0] jalr_imm,
  input  logic                   trap,
  input  logic        [XLEN-1:0] trap_vector,
  input  logic                   fetch_ready,
  output logic        [XLEN-1:0] pc,
  output logic                   fetch_valid,
  output logic                   flush,
  output logic                   misaligned
`ifdef PC_FETCH_CNT_EN
  ,
  output logic       [CNT_W-1:0] fetch_count
`endif
);

  pc_src_t         src;
  logic [XLEN-1:0] target;
  logic            tgt_misaligned;
  logic            redirect;
  logic            accept;
  logic            valid_q;

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .jalr_taken  (jalr_taken),
    .jalr_base   (jalr_base),
    .jalr_imm    (jalr_imm),
    .trap        (trap),
    .trap_vector (trap_vector),
    .src         (src),
    .target      (target),
    .misaligned  (tgt_misaligned)
  );

  assign redirect    = (src != PC_SRC_SEQ) && !tgt_misaligned;
  assign fetch_valid = valid_q && !stall;
  assign accept      = fetch_valid && fetch_ready;

  // A rejected (misaligned) redirect freezes the PC for that edge rather than advancing it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= RESET_VECTOR;
      valid_q    <= 1'b0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      flush      <= redirect;
      misaligned <= tgt_misaligned;
      valid_q    <= !redirect;
      if (redirect) begin
        pc <= target;
      end else if (!tgt_misaligned && accept) begin
        pc <= pc + XLEN'(STEP);
      end
    end
  end

`ifdef PC_FETCH_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count <= '0;
    end else if (!redirect && !tgt_misaligned && accept) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a
// behavioural model. Counter checks are active when PC_FETCH_CNT_EN is defined.
module tb_pc_sequencer;

  localparam int              XLEN = 64;
  localparam logic [XLEN-1:0] RV   = 64'h1000;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   stall;
  logic                   br_taken;
  logic        [XLEN-1:0] br_pc;
  logic signed [XLEN-1:0] br_imm;
  logic                   jalr_taken;
  logic        [XLEN-1:0] jalr_base;
  logic signed [XLEN-1:0] jalr_imm;
  logic                   trap;
  logic        [XLEN-1:0] trap_vector;
  logic                   fetch_ready;
  logic        [XLEN-1:0] pc;
  logic                   fetch_valid;
  logic                   flush;
  logic                   misaligned;
`ifdef PC_FETCH_CNT_EN
  logic [31:0]            fetch_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [XLEN-1:0] m_pc;
  bit              m_valid;
  bit              m_flush;
  bit              m_mis;
  logic [31:0]     m_cnt;

  pc_sequencer #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .STEP(4), .CNT_W(32)
  ) dut (
    .CLK(CLK), .RST(RST), .stall(stall),
    .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
    .jalr_taken(jalr_taken), .jalr_base(jalr_base), .jalr_imm(jalr_imm),
    .trap(trap), .trap_vector(trap_vector), .fetch_ready(fetch_ready),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .misaligned(misaligned)
`ifdef PC_FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic clear_redirects();
    br_taken = 0; jalr_taken = 0; trap = 0;
    br_pc = '0; br_imm = '0; jalr_base = '0; jalr_imm = '0; trap_vector = '0;
  endtask

  // Advance the model by the spec rules using the current inputs, then clock the DUT.
  task automatic tick();
    logic [XLEN-1:0] t;
    bit redir, mis, acc;
    redir = 0; mis = 0; t = '0;
    acc = m_valid && !stall && fetch_ready;
    if (trap) begin
      t = trap_vector; redir = 1;
    end else if (jalr_taken) begin
      t = (jalr_base + jalr_imm) & ~64'd1;
      if (t % 4 != 0) mis = 1; else redir = 1;
    end else if (br_taken) begin
      t = br_pc + br_imm;
      if (t % 4 != 0) mis = 1; else redir = 1;
    end
    if (RST) begin
      m_pc = RV; m_valid = 0; m_flush = 0; m_mis = 0; m_cnt = 0;
    end else begin
      m_flush = redir;
      m_mis   = mis;
      if (redir) m_pc = t;
      else if (!mis && acc) begin
        m_pc  = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
      m_valid = !redir;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; stall = 0; fetch_ready = 0; clear_redirects();
    tick(); tick();
    checks++; if (pc !== RV) begin failures++; $display("FAIL reset_pc actual=%h required=%h", pc, RV); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", fetch_valid); end
    checks++; if (flush !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL reset_pulses actual flush=%b mis=%b required 0/0", flush, misaligned); end
`ifdef PC_FETCH_CNT_EN
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_cnt actual=%0d required=0", fetch_count); end
`endif
    RST = 0;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL valid_before_edge actual=%b required=0", fetch_valid); end
    tick();
    checks++; if (fetch_valid !== 1'b1 || pc !== RV) begin failures++; $display("FAIL valid_after_reset actual valid=%b pc=%h required 1/%h", fetch_valid, pc, RV); end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] exp;
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = RV + 64'(4 * (i + 1));
      checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc[%0d] actual=%h required=%h", i, pc, exp); end
    end
`ifdef PC_FETCH_CNT_EN
    checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL seq_cnt actual=%0d required=4", fetch_count); end
`endif
    fetch_ready = 0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 64'h1010 || fetch_valid !== 1'b1) begin failures++; $display("FAIL hold_notready[%0d] actual pc=%h valid=%b required 1010/1", i, pc, fetch_valid); end
    end
    stall = 1; fetch_ready = 1;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_comb actual=%b required=0", fetch_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 64'h1010 || fetch_valid !== 1'b0) begin failures++; $display("FAIL hold_stall[%0d] actual pc=%h valid=%b required 1010/0", i, pc, fetch_valid); end
    end
    stall = 0; fetch_ready = 0;
  endtask

  task automatic test_priority();
    br_taken = 1; br_pc = 64'h2000; br_imm = -64'sd8;
    trap = 1; trap_vector = 64'h8000; fetch_ready = 1;
    tick();
    clear_redirects(); fetch_ready = 0;
    #1;
    checks++; if (pc !== 64'h8000 || flush !== 1'b1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL trap_priority actual pc=%h flush=%b valid=%b required 8000/1/0", pc, flush, fetch_valid); end
    tick();
    checks++; if (flush !== 1'b0 || fetch_valid !== 1'b1 || pc !== 64'h8000) begin failures++; $display("FAIL trap_after actual pc=%h flush=%b valid=%b required 8000/0/1", pc, flush, fetch_valid); end
  endtask

  task automatic test_jalr_misaligned();
    jalr_taken = 1; jalr_base = 64'h3001; jalr_imm = 64'sh10;
    tick();
    clear_redirects();
    checks++; if (pc !== 64'h3010 || flush !== 1'b1) begin failures++; $display("FAIL jalr_target actual pc=%h flush=%b required 3010/1", pc, flush); end
    tick();
    br_taken = 1; br_pc = 64'h2000; br_imm = 64'sh6; fetch_ready = 1;
    tick();
    clear_redirects(); fetch_ready = 0;
    checks++; if (pc !== 64'h3010 || misaligned !== 1'b1 || flush !== 1'b0) begin failures++; $display("FAIL br_misaligned actual pc=%h mis=%b flush=%b required 3010/1/0", pc, misaligned, flush); end
    tick();
    checks++; if (misaligned !== 1'b0 || pc !== 64'h3010) begin failures++; $display("FAIL mis_pulse actual mis=%b pc=%h required 0/3010", misaligned, pc); end
  endtask

  task automatic test_wrap();
    trap = 1; trap_vector = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    clear_redirects();
    tick();
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    checks++; if (pc !== 64'h0) begin failures++; $display("FAIL pc_wrap actual=%h required=0", pc); end
  endtask

  task automatic test_reset_mid();
    trap = 1; trap_vector = 64'h5000; fetch_ready = 1; RST = 1;
    tick();
    clear_redirects(); RST = 0; fetch_ready = 0;
    checks++; if (pc !== RV || flush !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_mid actual pc=%h flush=%b valid=%b required %h/0/0", pc, flush, fetch_valid, RV); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST         = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      fetch_ready = $urandom_range(0, 1);
      trap        = ($urandom_range(0, 15) == 0);
      jalr_taken  = ($urandom_range(0, 9) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      trap_vector = {$urandom, $urandom};
      jalr_base   = {$urandom, $urandom};
      jalr_imm    = 64'($signed(12'($urandom)));
      br_pc       = {$urandom, $urandom} & ~64'd3;
      br_imm      = 64'($signed(13'($urandom)));
      #1;
      checks++; if (fetch_valid !== (m_valid && !stall)) begin failures++; $display("FAIL rnd_valid[%0d] actual=%b required=%b", i, fetch_valid, m_valid && !stall); end
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] actual=%h required=%h", i, pc, m_pc); end
      checks++; if (flush !== m_flush || misaligned !== m_mis) begin failures++; $display("FAIL rnd_pulses[%0d] actual flush=%b mis=%b required %b/%b", i, flush, misaligned, m_flush, m_mis); end
`ifdef PC_FETCH_CNT_EN
      checks++; if (fetch_count !== m_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] actual=%0d required=%0d", i, fetch_count, m_cnt); end
`endif
    end
    RST = 0; stall = 0; fetch_ready = 0; clear_redirects();
  endtask

  initial begin
    m_pc = RV; m_valid = 0; m_flush = 0; m_mis = 0; m_cnt = 0;
    test_reset();
    test_sequential();
    test_hold();
    test_priority();
    test_jalr_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
